imem_responder: RTL
===================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 256, number of 32-bit instruction words held; a power of two, at least 4.
REQ-002 Parameter NOP_WORD, default 32'h0000_0013, instruction returned on an error response.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous and active-high.
REQ-005 Port req_valid, input, 1, fetch request present.
REQ-006 Port req_ready, output, 1, request accepted this cycle if req_valid is also high.
REQ-007 Port req_addr, input, 32, byte address from the program counter.
REQ-008 Port resp_valid, output, 1, response at the head of the queue.
REQ-009 Port resp_ready, input, 1, consumer takes the head response.
REQ-010 Port resp_instr, output, 32, fetched instruction word.
REQ-011 Port resp_err, output, 1, head response is an error (misaligned or out of range).
REQ-012 Port flush, input, 1, discard all queued responses (PC redirect).
REQ-013 Port ld_en, input, 1, program-load write enable.
REQ-014 Port ld_addr, input, log2(MEM_WORDS), program-load word index.
REQ-015 Port ld_data, input, 32, program-load write data.
REQ-016 Port err_count, output, 8, saturating count of error responses pushed into the queue.

Function
REQ-017 Accept = req_valid && req_ready, evaluated at the rising edge.
REQ-018 req_ready SHALL be (queue count < 2) && !flush, with no combinational path from resp_ready.
REQ-019 Memory read is combinational on req_addr[log2(MEM_WORDS)+1:2]; on accept, the result is pushed into a 2-entry in-order response FIFO at the same edge, giving 1-cycle latency.
REQ-020 Error: req_addr[1:0] != 0, or req_addr[31:2] >= MEM_WORDS; the entry SHALL hold err=1 and instr=NOP_WORD.
REQ-021 Non-error entry: err=0, instr=mem[req_addr[31:2]].
REQ-022 resp_valid = (count != 0); resp_instr/resp_err reflect the head entry when valid, else 0.
REQ-023 Pop = resp_valid && resp_ready; simultaneous push and pop leaves count unchanged and preserves order.
REQ-024 Pop when empty SHALL have no effect; push is impossible when full per REQ-018.
REQ-025 flush high at an edge: count becomes 0, head/tail pointers reset, no push, and any pop that edge is ignored.
REQ-026 ld_en writes ld_data to mem[ld_addr] at the edge; a fetch accepted at the same edge to the same word captures the old contents.
REQ-027 ld_en is independent of flush and of FIFO state; memory contents are not reset.
REQ-028 err_count increments by 1 per pushed error entry and holds at 255; flushed entries still count.
REQ-029 Response order SHALL equal acceptance order; no entry is duplicated or lost except by flush.

Reset
REQ-030 rst high SHALL immediately clear count, the pointers, and err_count, and force resp_valid=0, resp_instr=0, resp_err=0, regardless of clk.
REQ-031 While rst is high, req_ready SHALL be 0 and ld_en SHALL have no effect; operation resumes at the first edge after rst falls.
REQ-032 rst asserted mid-stream discards all queued responses; no partial response is ever presented.

Verification
REQ-033 Load mem[0..3]=A0..A3; requests 0x0,0x4 back-to-back with resp_ready=1 -> resp A0 one cycle after the first accept, then A1, resp_err=0.
REQ-034 resp_ready=0, three requests 0x0,0x4,0x8 -> first two accepted, req_ready=0 on the third; release resp_ready -> A0, A1, then 0x8 accepted -> A2.
REQ-035 Request 0x2 and request MEM_WORDS*4 -> two responses with resp_err=1, resp_instr=32'h0000_0013, err_count=2.
REQ-036 Two entries queued, flush=1 for one cycle -> resp_valid=0 next cycle, req_ready=0 during flush, new request after flush returns correct data.
REQ-037 ld_en to word 5 with new value N while fetching 0x14 at the same edge -> old value returned; refetch 0x14 -> N.
REQ-038 Assert rst asynchronously between edges with a full queue -> resp_valid, err_count, and req_ready go to 0 without a clock edge.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: combinational word read at the request edge,
// buffered in a 2-entry in-order response FIFO, with a program-load write port.
module imem_responder #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_addr,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [31:0]                  resp_instr,
  output logic                         resp_err,
  input  logic                         flush,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
  input  logic [31:0]                  ld_data,
  output logic [7:0]                   err_count
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0] slot_instr_q [2];
  logic [31:0] slot_instr_d [2];
  logic        slot_err_q   [2];
  logic        slot_err_d   [2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        push;
  logic        pop;
  logic        entry_err;
  logic [31:0] entry_instr;
  logic [31:0] fetch_word;

  // Memory has no reset; loads are blocked while rst is held.
  always_ff @(posedge clk) begin
    if (ld_en && !rst) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  assign fetch_word  = mem_q[req_addr[AW+1:2]];
  assign entry_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
  assign entry_instr = entry_err ? NOP_WORD : fetch_word;

  assign req_ready = (count_q < 2'd2) && !flush && !rst;
  assign push      = req_valid && req_ready;
  assign pop       = (count_q != 2'd0) && resp_ready;

  always_comb begin
    slot_instr_d = slot_instr_q;
    slot_err_d   = slot_err_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    err_count_d  = err_count_q;

    if (flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        slot_instr_d[tail_q] = entry_instr;
        slot_err_d[tail_q]   = entry_err;
        tail_d               = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    if (push && entry_err && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_instr_q <= '{default: '0};
      slot_err_q   <= '{default: 1'b0};
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      count_q      <= 2'd0;
      err_count_q  <= 8'd0;
    end else begin
      slot_instr_q <= slot_instr_d;
      slot_err_q   <= slot_err_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      err_count_q  <= err_count_d;
    end
  end

  // Outputs are gated by count so an async reset blanks them at once.
  assign resp_valid = (count_q != 2'd0);
  assign resp_instr = resp_valid ? slot_instr_q[head_q] : 32'd0;
  assign resp_err   = resp_valid ? slot_err_q[head_q] : 1'b0;
  assign err_count  = err_count_q;

endmodule
